// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter and select sequencer for the 31:1 x 2-bit datapath mux.
// Grants one requester at a time, bounded by a per-grant burst limit.
module mux_rr_arbiter #(
  parameter int N_REQ     = 31,
  parameter int MAX_BURST = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [30:0] req,
  input  logic        out_ready,
  output logic [4:0]  sel,
  output logic [30:0] gnt,
  output logic        out_valid
);

  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [30:0] MASK = 31'((64'd1 << N_REQ) - 64'd1);
  localparam logic [4:0] LAST_IDX = 5'(N_REQ - 1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(MAX_BURST - 1);

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t        state;
  logic [4:0]    owner;
  logic [4:0]    ptr;
  logic [BW-1:0] beat_cnt;

  logic [30:0] req_m;
  logic        busy;
  logic        accept;
  logic        release_now;
  logic [4:0]  ptr_nx;
  logic [4:0]  winner;
  logic        any;

  assign req_m  = req & MASK;
  assign any    = |req_m;
  assign busy   = (state == BUSY);

  assign out_valid = busy & req[owner];
  assign accept    = out_valid & out_ready;

  // Release on owner drop or on the final beat of a burst.
  assign release_now = busy & (~req[owner] | (accept & (beat_cnt == LAST_BEAT)));

  // Releasing owner drops to lowest priority for the same-cycle rearbitration.
  always_comb begin
    ptr_nx = ptr;
    if (release_now) begin
      ptr_nx = (owner == LAST_IDX) ? 5'd0 : 5'(owner + 5'd1);
    end
  end

  // First requester at or after ptr_nx, wrapping at N_REQ.
  always_comb begin
    int         idx;
    logic [4:0] idx5;
    logic       found;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    idx5   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(ptr_nx) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      idx5 = 5'(idx);
      if (!found && req_m[idx5]) begin
        winner = idx5;
        found  = 1'b1;
      end
    end
  end

  // Grant state machine: owner, rotation pointer and burst count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      owner    <= '0;
      ptr      <= '0;
      beat_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (any) begin
            state    <= BUSY;
            owner    <= winner;
            beat_cnt <= '0;
          end
        end
        BUSY: begin
          if (release_now) begin
            ptr <= ptr_nx;
            if (any) begin
              owner    <= winner;
              beat_cnt <= '0;
            end else begin
              state <= IDLE;
            end
          end else if (accept) begin
            beat_cnt <= beat_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign sel = busy ? owner : 5'd31;
  assign gnt = busy ? (31'd1 << owner) : 31'd0;

endmodule

// File: doc/mux_rr_arbiter.md
# mux_rr_arbiter

Round-robin arbiter and select sequencer for the 31-input, 2-bit-wide select mux in the datapath. It takes one request line per mux input, grants at most one requester at a time, and drives the mux select so the granted input's data reaches the shared output. A valid/ready handshake qualifies each 2-bit beat toward the consumer. A per-grant burst limit bounds how long one requester can hold the mux.

## Interface
- N_REQ, 31, number of active requesters (legal range 1..31); mux inputs at index >= N_REQ are never granted.
- MAX_BURST, 4, maximum accepted beats per grant (legal range 1..255); 0 is illegal.

- clk  input  1  clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  31  request per mux input; bit i asks for inp<i>; bits >= N_REQ ignored.
- out_ready  input  1  consumer accepts the current beat.
- sel  output  5  mux select; 5'd31 when no grant, so the mux outputs 0 through its default arm.
- gnt  output  31  one-hot grant; all-zero when idle.
- out_valid  output  1  current mux output is a valid beat.

## Operation
- State registers: state (IDLE/BUSY), owner[4:0], ptr[4:0] (round-robin start index), beat_cnt (width clog2(MAX_BURST+1)).
- Arbitration function: the first index i with req[i]=1, scanning ptr, ptr+1, … N_REQ-1, 0, … ptr-1. Only bits < N_REQ participate.
- IDLE:
  - Outputs: sel=31, gnt=0, out_valid=0.
  - If any req is set, next state is BUSY, owner=winner, beat_cnt=0.
- BUSY:
  - Outputs: sel=owner, gnt=1<<owner, out_valid=req[owner] (combinational).
  - A beat is accepted when out_valid && out_ready; each accepted beat increments beat_cnt.
- Release occurs on either condition:
  - (a) req[owner]=0 in a BUSY cycle. No beat is accepted that cycle.
  - (b) A beat is accepted with beat_cnt == MAX_BURST-1.
- On release:
  - ptr <= owner+1, wrapping N_REQ-1 to 0.
  - Arbitration uses that updated ptr in the same cycle. If any req (bits < N_REQ) is set, state stays BUSY with the new owner and beat_cnt=0, so grants are back-to-back. Otherwise the next state is IDLE.
  - The releasing owner has lowest priority. It re-wins only if it is the sole requester.
- A requester that drops req while another holds the grant loses nothing. There is no queueing and no memory of past requests beyond ptr.
- out_ready is ignored in IDLE. out_ready low in BUSY stalls: owner and beat_cnt hold, and the grant is kept indefinitely while req[owner]=1.
- N_REQ=1: owner is always 0. Release/regrant cycles keep gnt=1 continuously.

## Timing
- Reset (rst_n=0, takes effect immediately, asynchronous): state=IDLE, owner=0, ptr=0, beat_cnt=0. Outputs become sel=31, gnt=0, out_valid=0.
- Reset mid-burst aborts the grant with no completion beat. The first arbitration after reset scans from index 0.
- Request-to-grant latency: 1 cycle. req is sampled at edge k, and sel/gnt update after edge k.
- sel and gnt are registered, with no combinational path from req or out_ready. out_valid is combinational from req, gated by registered state.
- A grant switch on release takes effect at the next edge. There is no idle bubble between owners when requests are pending.
- Worst-case wait for a continuously requesting input: (N_REQ-1) grants of at most MAX_BURST accepted beats each, plus stall cycles.

## Test plan
- Reset/idle: rst_n=0, then 1, with req=0 → sel=31, gnt=0, out_valid=0 held for 10 cycles.
- Single requester burst: req[5]=1 held, out_ready=1, MAX_BURST=4 → sel=5 one cycle after req. out_valid=1 for 4 accepted beats. Release, then immediate regrant to 5 (sole requester) with sel steady at 5.
- Round-robin rotation: req[2], req[7], req[30] all held, out_ready=1 → owners cycle 2, 7, 30, 2, … with 4 beats each. The wrap from 30 back to 0 resolves to 2.
- Early drop: owner 7 drops req after 2 beats while req[9]=1 → release with no third beat. Next cycle sel=9, and ptr is 8.
- Stall: owner 3, out_ready=0 for 20 cycles → sel=3 and beat_cnt held. After out_ready returns high, exactly MAX_BURST beats are accepted.
- Async reset mid-burst: rst_n low for half a cycle during owner 12's second beat → sel=31 and gnt=0 immediately. After release with req[12] and req[1] set, the first grant goes to 1 (ptr=0).
